direct_mapped_cache: RTL and testbench
======================================

DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 The block SHALL have parameter cache_id, default 0, which selects the cache instance; it SHALL affect only the dump file name, never function.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit; when 0, no state changes and all outputs are 0.
REQ-005 The block SHALL have port createdump, input, 1 bit; simulation-only request to dump contents.
REQ-006 The block SHALL have port tag_in, input, 5 bits, the tag to compare or install.
REQ-007 The block SHALL have port index, input, 8 bits, the line select (256 lines).
REQ-008 The block SHALL have port offset, input, 3 bits, the byte offset; offset[2:1] is the word select (4 words of 16 bits per line).
REQ-009 The block SHALL have port data_in, input, 16 bits, the write data.
REQ-010 The block SHALL have port comp, input, 1 bit; 1 = compare mode, 0 = access mode.
REQ-011 The block SHALL have port write, input, 1 bit; 1 = write, 0 = read.
REQ-012 The block SHALL have port valid_in, input, 1 bit, the valid bit installed on an access write.
REQ-013 The block SHALL have port tag_out, output, 5 bits, the stored tag of the indexed line.
REQ-014 The block SHALL have port data_out, output, 16 bits, the stored word at index/offset[2:1].
REQ-015 The block SHALL have port hit, output, 1 bit; 1 = compare-mode tag match.
REQ-016 The block SHALL have port dirty, output, 1 bit, the dirty bit of the indexed line.
REQ-017 The block SHALL have port valid, output, 1 bit, the valid bit of the indexed line.
REQ-018 The block SHALL have port err, output, 1 bit, the illegal-access flag.

Function
REQ-019 Storage SHALL be 256 lines, each holding a 5-bit tag, a valid bit, a dirty bit and 4x16-bit words.
REQ-020 All outputs SHALL be combinational from current state and inputs (zero-cycle read latency); writes SHALL take effect at the next rising clk.
REQ-021 When enable=1, tag_out, valid, dirty and data_out SHALL reflect the indexed line's pre-write contents in every mode.
REQ-022 Compare mode: hit SHALL be (stored tag == tag_in), independent of valid; the consumer qualifies it with valid.
REQ-023 Access mode: hit SHALL be 0.
REQ-024 Compare read (comp=1, write=0) SHALL not modify state.
REQ-025 Compare write (comp=1, write=1): if hit and valid, the addressed word SHALL be written with data_in and dirty set to 1; otherwise no state change.
REQ-026 Access read (comp=0, write=0) SHALL not modify state.
REQ-027 Access write (comp=0, write=1): the addressed word SHALL be written with data_in, tag set to tag_in, valid set to valid_in, and dirty cleared to 0.
REQ-028 err SHALL be 1 when enable=1 and offset[0]=1 (misaligned), or when enable=1 and any control input is X/Z; an erroring access SHALL modify no state.
REQ-029 On rising clk with createdump=1, the block SHALL write all valid lines (index, tag, dirty, words) to file "dumpfile_<cache_id>"; this has no functional effect.

Reset
REQ-030 rst=1 at a rising clk SHALL clear all valid and dirty bits; tags and data are don't-care after reset.
REQ-031 rst SHALL take priority over any simultaneous write.
REQ-032 Outputs SHALL still follow REQ-021 during reset, showing valid=0 after the first reset edge.

Verification
REQ-033 Reset, then compare read index 5 tag 3 -> valid=0, dirty=0, err=0.
REQ-034 Access writes to index 5, tag 3, offsets 0/2/4/6 with data 0x1111/0x2222/0x3333/0x4444, valid_in=1 on all -> compare read tag 3 offset 4 gives data_out=0x3333, hit=1, valid=1, dirty=0.
REQ-035 Compare write index 5 tag 3 offset 2 data 0xBEEF -> next compare read gives 0xBEEF, dirty=1; compare read tag 4 gives hit=0, valid=1, dirty=1, tag_out=3.
REQ-036 Compare write index 7 (invalid) tag 1 -> line 7 stays valid=0, dirty=0.
REQ-037 Any access with offset=1 -> err=1, no state change; with enable=0 -> all outputs 0.
REQ-038 Assert rst after REQ-035 -> compare read index 5 gives valid=0, dirty=0.

Source files
------------

// File: rtl/direct_mapped_cache.sv
// Direct-mapped cache array: 256 lines, each holding a 5-bit tag, valid and
// dirty bits, and four 16-bit words. Reads are combinational. Writes commit
// on the rising clock edge. Compare mode checks the stored tag; access mode
// installs a line.
module direct_mapped_cache #(
  parameter int cache_id = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        createdump,
  input  logic [4:0]  tag_in,
  input  logic [7:0]  index,
  input  logic [2:0]  offset,
  input  logic [15:0] data_in,
  input  logic        comp,
  input  logic        write,
  input  logic        valid_in,
  output logic [4:0]  tag_out,
  output logic [15:0] data_out,
  output logic        hit,
  output logic        dirty,
  output logic        valid,
  output logic        err
);

  // Per-line status bits are kept as flat vectors so reset can clear them in one step.
  // Tags and data carry no reset, which lets them map onto plain RAM.
  logic [255:0] valid_bits;
  logic [255:0] dirty_bits;
  logic [4:0]   tag_mem  [256];
  logic [15:0]  data_mem [1024];

  logic [9:0]  word_addr;
  logic [4:0]  line_tag;
  logic [15:0] line_word;
  logic        line_valid;
  logic        line_dirty;
  logic        tag_match;
  logic        ctrl_unknown;
  logic        bad_access;
  logic        do_write;
  logic        access_wr;
  logic        compare_wr;
  logic        word_wr;

  // The dump request and the instance number only name a simulation dump file.
  // They are folded into a sink so the datapath never depends on them.
  logic        unused_dump;
  assign unused_dump = createdump ^ (cache_id != 0);

  assign word_addr  = {index, offset[2:1]};
  assign line_tag   = tag_mem[index];
  assign line_word  = data_mem[word_addr];
  assign line_valid = valid_bits[index];
  assign line_dirty = dirty_bits[index];
  assign tag_match  = (line_tag == tag_in);

  // Unknown control inputs are treated like a misaligned offset. The access is
  // flagged and blocked from writing anything.
  assign ctrl_unknown = $isunknown({comp, write, valid_in, offset});
  assign bad_access   = enable & (offset[0] | ctrl_unknown);

  assign do_write   = enable & write & ~bad_access;
  assign access_wr  = do_write & ~comp;
  assign compare_wr = do_write & comp & tag_match & line_valid;
  assign word_wr    = access_wr | compare_wr;

  // Output mux: show the pre-write contents of the indexed line while enabled.
  // Hold every output at zero while the cache is disabled.
  always_comb begin
    tag_out  = '0;
    data_out = '0;
    hit      = 1'b0;
    dirty    = 1'b0;
    valid    = 1'b0;
    err      = 1'b0;
    if (enable) begin
      tag_out  = line_tag;
      data_out = line_word;
      hit      = comp & tag_match;
      dirty    = line_dirty;
      valid    = line_valid;
      err      = bad_access;
    end
  end

  // Status bits: reset wipes every line and overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (access_wr) begin
      valid_bits[index] <= valid_in;
      dirty_bits[index] <= 1'b0;
    end else if (compare_wr) begin
      dirty_bits[index] <= 1'b1;
    end
  end

  // Tag storage: only an access-mode write installs a new tag.
  always_ff @(posedge clk) begin
    if (!rst && access_wr) begin
      tag_mem[index] <= tag_in;
    end
  end

  // Word storage: an access write, or a compare write that hits a valid line.
  always_ff @(posedge clk) begin
    if (!rst && word_wr) begin
      data_mem[word_addr] <= data_in;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache. Inputs change on the falling edge.
// Outputs are checked 1 ns later. Writes commit on the following rising edge.
module tb_direct_mapped_cache;

  logic        clk = 1'b0;
  logic        rst, enable, createdump, comp, write, valid_in;
  logic [4:0]  tag_in;
  logic [7:0]  index;
  logic [2:0]  offset;
  logic [15:0] data_in;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic        hit, dirty, valid, err;

  int n_compared   = 0;
  int n_mismatched = 0;

  direct_mapped_cache #(.cache_id(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .createdump(createdump),
    .tag_in(tag_in), .index(index), .offset(offset), .data_in(data_in),
    .comp(comp), .write(write), .valid_in(valid_in),
    .tag_out(tag_out), .data_out(data_out), .hit(hit), .dirty(dirty),
    .valid(valid), .err(err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Drive one request after the falling edge, then settle 1 ns before checks.
  task automatic applyStimulus(input logic r, input logic en, input logic c,
                               input logic w, input logic [7:0] idx,
                               input logic [4:0] tg, input logic [2:0] off,
                               input logic [15:0] d, input logic vin);
    @(negedge clk);
    rst = r; enable = en; comp = c; write = w; index = idx;
    tag_in = tg; offset = off; data_in = d; valid_in = vin;
    #1;
  endtask

  // One tagged comparison of an observed output against its expected value.
  task automatic checkOutput(input string name, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; createdump = 1'b0; comp = 1'b0; write = 1'b0;
    valid_in = 1'b0; tag_in = '0; index = '0; offset = '0; data_in = '0;

    // Reset, then compare read of an empty line.
    applyStimulus(1, 1, 1, 0, 8'd5, 5'd3, 3'd0, 16'h0, 0);
    @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd0, 16'h0, 0);
    checkOutput("reset_valid", 16'(valid), 16'd0);
    checkOutput("reset_dirty", 16'(dirty), 16'd0);
    checkOutput("reset_err",   16'(err),   16'd0);

    // Fill line 5, tag 3, all four words.
    applyStimulus(0, 1, 0, 1, 8'd5, 5'd3, 3'd0, 16'h1111, 1);
    checkOutput("access_wr_hit0", 16'(hit), 16'd0);
    @(posedge clk);
    applyStimulus(0, 1, 0, 1, 8'd5, 5'd3, 3'd2, 16'h2222, 1); @(posedge clk);
    applyStimulus(0, 1, 0, 1, 8'd5, 5'd3, 3'd4, 16'h3333, 1); @(posedge clk);
    applyStimulus(0, 1, 0, 1, 8'd5, 5'd3, 3'd6, 16'h4444, 1); @(posedge clk);

    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd4, 16'h0, 0);
    checkOutput("fill_data4", data_out, 16'h3333);
    checkOutput("fill_hit",   16'(hit),   16'd1);
    checkOutput("fill_valid", 16'(valid), 16'd1);
    checkOutput("fill_dirty", 16'(dirty), 16'd0);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd0, 16'h0, 0);
    checkOutput("fill_data0", data_out, 16'h1111);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd6, 16'h0, 0);
    checkOutput("fill_data6", data_out, 16'h4444);

    // Compare write hits; the outputs still show pre-write contents before the edge.
    applyStimulus(0, 1, 1, 1, 8'd5, 5'd3, 3'd2, 16'hBEEF, 0);
    checkOutput("cw_pre_data",  data_out, 16'h2222);
    checkOutput("cw_pre_dirty", 16'(dirty), 16'd0);
    checkOutput("cw_pre_hit",   16'(hit),   16'd1);
    @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd2, 16'h0, 0);
    checkOutput("cw_data",  data_out, 16'hBEEF);
    checkOutput("cw_dirty", 16'(dirty), 16'd1);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd4, 3'd2, 16'h0, 0);
    checkOutput("miss_hit",   16'(hit),   16'd0);
    checkOutput("miss_valid", 16'(valid), 16'd1);
    checkOutput("miss_dirty", 16'(dirty), 16'd1);
    checkOutput("miss_tag",   16'(tag_out), 16'd3);

    // A compare write that misses on the tag must leave the word untouched.
    applyStimulus(0, 1, 1, 1, 8'd5, 5'd4, 3'd6, 16'h5555, 0); @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd6, 16'h0, 0);
    checkOutput("miss_wr_data", data_out, 16'h4444);

    // A compare write to an invalid line is ignored.
    applyStimulus(0, 1, 1, 1, 8'd7, 5'd1, 3'd0, 16'hAAAA, 0); @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd7, 5'd1, 3'd0, 16'h0, 0);
    checkOutput("inv_valid", 16'(valid), 16'd0);
    checkOutput("inv_dirty", 16'(dirty), 16'd0);

    // A misaligned access write raises err and changes nothing.
    applyStimulus(0, 1, 0, 1, 8'd5, 5'd9, 3'd1, 16'hDEAD, 1);
    checkOutput("mis_err", 16'(err), 16'd1);
    @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd0, 16'h0, 0);
    checkOutput("mis_tag",   16'(tag_out), 16'd3);
    checkOutput("mis_data",  data_out, 16'h1111);
    checkOutput("mis_dirty", 16'(dirty), 16'd1);
    checkOutput("mis_err_clr", 16'(err), 16'd0);

    // Disabled: outputs are zero and a write is ignored.
    applyStimulus(0, 0, 0, 1, 8'd5, 5'd9, 3'd2, 16'hDEAD, 1);
    checkOutput("dis_data",  data_out, 16'h0);
    checkOutput("dis_tag",   16'(tag_out), 16'd0);
    checkOutput("dis_flags", 16'({hit, dirty, valid, err}), 16'd0);
    @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd2, 16'h0, 0);
    checkOutput("dis_keep_data", data_out, 16'hBEEF);
    checkOutput("dis_keep_tag",  16'(tag_out), 16'd3);

    // An access write with valid_in=0 installs an invalid line.
    applyStimulus(0, 1, 0, 1, 8'd9, 5'd2, 3'd0, 16'h7777, 0); @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd9, 5'd2, 3'd0, 16'h0, 0);
    checkOutput("vin0_valid", 16'(valid), 16'd0);
    checkOutput("vin0_data",  data_out, 16'h7777);

    // Reset beats a simultaneous access write; outputs track the line throughout.
    applyStimulus(1, 1, 0, 1, 8'd5, 5'd3, 3'd0, 16'h9999, 1);
    checkOutput("rst_pre_valid", 16'(valid), 16'd1);
    @(posedge clk);
    applyStimulus(0, 1, 1, 0, 8'd5, 5'd3, 3'd0, 16'h0, 0);
    checkOutput("rst2_valid", 16'(valid), 16'd0);
    checkOutput("rst2_dirty", 16'(dirty), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
